// File: rtl/pkt_hdr_pkg.sv
// Shared types, pass-range limits and bit-width helpers for the packet-header codeword generator.
package pkt_hdr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    ZBP,
    ZBP_END,
    PASSES,
    LBLK_ONES,
    LBLK_ZERO,
    LENGTH
  } hdr_state_e;

  localparam int PASS_ONE   = 1;
  localparam int PASS_TWO   = 2;
  localparam int PASS_MAX5  = 5;
  localparam int PASS_MAX36 = 36;
  localparam int PASS_MAX   = 164;

  // Number of bits needed to represent v; zero needs none.
  function automatic logic [5:0] bits_needed(input logic [31:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 6'(i + 1);
    end
    return r;
  endfunction

  function automatic logic [4:0] floor_log2(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/hdr_pass_cw_enc.sv
// Combinational coding-pass-count codeword encoder (right-justified data plus bit count).
module hdr_pass_cw_enc
  import pkt_hdr_pkg::*;
#(
  parameter int HDR_DATA_W = 32,
  parameter int BIT_CNT_W  = 6,
  parameter int PASS_W     = 8
) (
  input  logic [PASS_W-1:0]     passes_i,
  output logic [HDR_DATA_W-1:0] data_o,
  output logic [BIT_CNT_W-1:0]  cnt_o
);

  logic [PASS_W-1:0] off3, off6, off37;

  always_comb begin
    off3   = passes_i - PASS_W'(3);
    off6   = passes_i - PASS_W'(6);
    off37  = passes_i - PASS_W'(37);
    data_o = '0;
    cnt_o  = BIT_CNT_W'(1);
    if (int'(passes_i) <= PASS_ONE) begin
      data_o = '0;
      cnt_o  = BIT_CNT_W'(1);
    end else if (int'(passes_i) == PASS_TWO) begin
      data_o = HDR_DATA_W'(2'b10);
      cnt_o  = BIT_CNT_W'(2);
    end else if (int'(passes_i) <= PASS_MAX5) begin
      data_o = HDR_DATA_W'({2'b11, off3[1:0]});
      cnt_o  = BIT_CNT_W'(4);
    end else if (int'(passes_i) <= PASS_MAX36) begin
      data_o = HDR_DATA_W'({4'b1111, off6[4:0]});
      cnt_o  = BIT_CNT_W'(9);
    end else begin
      data_o = HDR_DATA_W'({9'h1FF, off37[6:0]});
      cnt_o  = BIT_CNT_W'(16);
    end
  end

endmodule

// File: rtl/pkt_hdr_cw_gen.sv
// JPEG2000 single-leaf packet-header codeword generator.
// Define PKT_HDR_STATS_EN to add hdr_bits_total_o, a running count of emitted header bits.
module pkt_hdr_cw_gen
  import pkt_hdr_pkg::*;
#(
  parameter int HDR_DATA_W  = 32,
  parameter int BIT_CNT_W   = 6,
  parameter int ZBP_W       = 5,
  parameter int PASS_W      = 8,
  parameter int LEN_W       = 16,
  parameter int LBLOCK_INIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cb_valid_i,
  output logic                  cb_ready_o,
  input  logic                  cb_incl_i,
  input  logic [ZBP_W-1:0]      cb_zbp_i,
  input  logic [PASS_W-1:0]     cb_passes_i,
  input  logic [LEN_W-1:0]      cb_len_i,
  output logic                  cw_valid_o,
  output logic                  cw_last_o,
  output logic                  cw_insert_zero_o,
  output logic                  cw_insert_ones_o,
  output logic [BIT_CNT_W-1:0]  cw_bit_cnt_o,
  output logic [HDR_DATA_W-1:0] cw_data_o,
  input  logic                  cw_ready_i,
  output logic                  err_o
`ifdef PKT_HDR_STATS_EN
  , output logic [31:0]         hdr_bits_total_o
`endif
);

  hdr_state_e state_q, state_d;
  logic                  incl_q, incl_d;
  logic [ZBP_W-1:0]      zbp_q, zbp_d;
  logic [PASS_W-1:0]     passes_q, passes_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [BIT_CNT_W-1:0]  k_q, k_d;
  logic [4:0]            fl_q, fl_d;
  logic                  cw_valid_q, cw_valid_d, cw_last_q, cw_last_d;
  logic                  cw_zero_q, cw_zero_d, cw_ones_q, cw_ones_d;
  logic [BIT_CNT_W-1:0]  cw_cnt_q, cw_cnt_d;
  logic [HDR_DATA_W-1:0] cw_data_q, cw_data_d;
  logic                  accept, illegal, advance;
  logic [5:0]            need;
  int                    thresh;
  logic [HDR_DATA_W-1:0] enc_data;
  logic [BIT_CNT_W-1:0]  enc_cnt;

  hdr_pass_cw_enc #(
    .HDR_DATA_W(HDR_DATA_W),
    .BIT_CNT_W (BIT_CNT_W),
    .PASS_W    (PASS_W)
  ) u_pass_enc (
    .passes_i(passes_d),
    .data_o  (enc_data),
    .cnt_o   (enc_cnt)
  );

  always_comb begin
    accept  = cb_valid_i && (state_q == IDLE);
    illegal = cb_incl_i && (cb_passes_i == '0 || int'(cb_passes_i) > PASS_MAX);
    advance = cw_valid_q && cw_ready_i;
    need    = bits_needed(32'(cb_len_i));
    state_d  = state_q;
    incl_d   = incl_q;
    zbp_d    = zbp_q;
    passes_d = passes_q;
    len_d    = len_q;
    k_d      = k_q;
    fl_d     = fl_q;
    thresh   = 0;
    if (accept) begin
      incl_d   = cb_incl_i && !illegal;
      zbp_d    = cb_zbp_i;
      passes_d = cb_passes_i;
      len_d    = cb_len_i;
      fl_d     = floor_log2(32'(cb_passes_i));
      thresh   = LBLOCK_INIT + int'(fl_d);
      k_d      = (int'(need) > thresh) ? BIT_CNT_W'(int'(need) - thresh) : '0;
      state_d  = HEAD;
    end else if (advance) begin
      case (state_q)
        HEAD:      state_d = !incl_q ? IDLE : (zbp_q != '0) ? ZBP : ZBP_END;
        ZBP:       state_d = ZBP_END;
        ZBP_END:   state_d = PASSES;
        PASSES:    state_d = (k_q != '0) ? LBLK_ONES : LBLK_ZERO;
        LBLK_ONES: state_d = LBLK_ZERO;
        LBLK_ZERO: state_d = LENGTH;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Output registers are loaded with the codeword of the state being entered.
  always_comb begin
    cw_valid_d = (state_d != IDLE);
    cw_last_d  = 1'b0;
    cw_zero_d  = 1'b0;
    cw_ones_d  = 1'b0;
    cw_cnt_d   = '0;
    cw_data_d  = '0;
    case (state_d)
      HEAD: begin
        cw_cnt_d  = incl_d ? BIT_CNT_W'(2) : BIT_CNT_W'(1);
        cw_data_d = incl_d ? HDR_DATA_W'(2'b11) : '0;
        cw_last_d = !incl_d;
      end
      ZBP: begin
        cw_zero_d = 1'b1;
        cw_cnt_d  = BIT_CNT_W'(zbp_d);
      end
      ZBP_END: begin
        cw_cnt_d  = BIT_CNT_W'(1);
        cw_data_d = HDR_DATA_W'(1);
      end
      PASSES: begin
        cw_cnt_d  = enc_cnt;
        cw_data_d = enc_data;
      end
      LBLK_ONES: begin
        cw_ones_d = 1'b1;
        cw_cnt_d  = k_d;
      end
      LBLK_ZERO: cw_cnt_d = BIT_CNT_W'(1);
      LENGTH: begin
        cw_cnt_d  = BIT_CNT_W'(LBLOCK_INIT) + k_d + BIT_CNT_W'(fl_d);
        cw_data_d = HDR_DATA_W'(len_d);
        cw_last_d = 1'b1;
      end
      default: cw_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      incl_q     <= 1'b0;
      zbp_q      <= '0;
      passes_q   <= '0;
      len_q      <= '0;
      k_q        <= '0;
      fl_q       <= '0;
      cw_valid_q <= 1'b0;
      cw_last_q  <= 1'b0;
      cw_zero_q  <= 1'b0;
      cw_ones_q  <= 1'b0;
      cw_cnt_q   <= '0;
      cw_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      incl_q     <= incl_d;
      zbp_q      <= zbp_d;
      passes_q   <= passes_d;
      len_q      <= len_d;
      k_q        <= k_d;
      fl_q       <= fl_d;
      cw_valid_q <= cw_valid_d;
      cw_last_q  <= cw_last_d;
      cw_zero_q  <= cw_zero_d;
      cw_ones_q  <= cw_ones_d;
      cw_cnt_q   <= cw_cnt_d;
      cw_data_q  <= cw_data_d;
    end
  end

  assign cb_ready_o       = (state_q == IDLE);
  assign err_o            = accept && illegal;
  assign cw_valid_o       = cw_valid_q;
  assign cw_last_o        = cw_last_q;
  assign cw_insert_zero_o = cw_zero_q;
  assign cw_insert_ones_o = cw_ones_q;
  assign cw_bit_cnt_o     = cw_cnt_q;
  assign cw_data_o        = cw_data_q;

`ifdef PKT_HDR_STATS_EN
  logic [31:0] hdr_bits_total_q, hdr_bits_total_d;

  always_comb begin
    hdr_bits_total_d = hdr_bits_total_q;
    if (advance) hdr_bits_total_d = hdr_bits_total_q + 32'(cw_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hdr_bits_total_q <= '0;
    else        hdr_bits_total_q <= hdr_bits_total_d;
  end

  assign hdr_bits_total_o = hdr_bits_total_q;
`endif

endmodule

// File: tb/tb_pkt_hdr_cw_gen.sv
// Directed scoreboard bench for pkt_hdr_cw_gen; expected codewords come from a reference model of the header format.
module tb_pkt_hdr_cw_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cb_valid_i = 1'b0;
  logic        cb_ready_o;
  logic        cb_incl_i = 1'b0;
  logic [4:0]  cb_zbp_i = '0;
  logic [7:0]  cb_passes_i = '0;
  logic [15:0] cb_len_i = '0;
  logic        cw_valid_o, cw_last_o, cw_insert_zero_o, cw_insert_ones_o;
  logic [5:0]  cw_bit_cnt_o;
  logic [31:0] cw_data_o;
  logic        cw_ready_i = 1'b1;
  logic        err_o;
`ifdef PKT_HDR_STATS_EN
  logic [31:0] hdr_bits_total_o;
  logic [31:0] exp_total = '0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [40:0] exp_q[$];

  always #5 clk = ~clk;

  pkt_hdr_cw_gen dut (
    .clk(clk), .rst_n(rst_n),
    .cb_valid_i(cb_valid_i), .cb_ready_o(cb_ready_o), .cb_incl_i(cb_incl_i),
    .cb_zbp_i(cb_zbp_i), .cb_passes_i(cb_passes_i), .cb_len_i(cb_len_i),
    .cw_valid_o(cw_valid_o), .cw_last_o(cw_last_o),
    .cw_insert_zero_o(cw_insert_zero_o), .cw_insert_ones_o(cw_insert_ones_o),
    .cw_bit_cnt_o(cw_bit_cnt_o), .cw_data_o(cw_data_o),
    .cw_ready_i(cw_ready_i), .err_o(err_o)
`ifdef PKT_HDR_STATS_EN
    , .hdr_bits_total_o(hdr_bits_total_o)
`endif
  );

  // {insert_zero, insert_ones, last, cnt[5:0], data[31:0]}
  function automatic logic [40:0] mk(logic z, logic o, logic l, int cnt, int unsigned data);
    return {z, o, l, 6'(cnt), 32'(data)};
  endfunction

  function automatic logic [40:0] obs_cw();
    return {cw_insert_zero_o, cw_insert_ones_o, cw_last_o, cw_bit_cnt_o, cw_data_o};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cw_valid_o && cw_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cw", {23'd0, obs_cw()}, 64'hDEAD);
      end else begin
        logic [40:0] e;
        e = exp_q.pop_front();
        check("codeword", {23'd0, obs_cw()}, {23'd0, e});
`ifdef PKT_HDR_STATS_EN
        exp_total = exp_total + 32'(e[37:32]);
`endif
      end
    end
  end

  task automatic model(input logic incl, input int zbp, input int p, input int len);
    int need, fl, k;
    if (!incl || p == 0 || p > 164) begin
      exp_q.push_back(mk(0, 0, 1, 1, 0));
      return;
    end
    exp_q.push_back(mk(0, 0, 0, 2, 3));
    if (zbp > 0) exp_q.push_back(mk(1, 0, 0, zbp, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    if (p == 1)       exp_q.push_back(mk(0, 0, 0, 1, 0));
    else if (p == 2)  exp_q.push_back(mk(0, 0, 0, 2, 2));
    else if (p <= 5)  exp_q.push_back(mk(0, 0, 0, 4, 12 + (p - 3)));
    else if (p <= 36) exp_q.push_back(mk(0, 0, 0, 9, 'h1E0 + (p - 6)));
    else              exp_q.push_back(mk(0, 0, 0, 16, 'hFF80 + (p - 37)));
    need = $clog2(len + 1);
    fl   = $clog2(p + 1) - 1;
    k    = (need - 3 - fl > 0) ? need - 3 - fl : 0;
    if (k > 0) exp_q.push_back(mk(0, 1, 0, k, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 1, 3 + k + fl, len));
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic incl, input int zbp, input int p, input int len);
    int n;
    n = 0;
    while (!cb_ready_o && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_send", {63'd0, cb_ready_o}, 64'd1);
    cb_valid_i  = 1'b1;
    cb_incl_i   = incl;
    cb_zbp_i    = 5'(zbp);
    cb_passes_i = 8'(p);
    cb_len_i    = 16'(len);
    model(incl, zbp, p, len);
    #1;
    check("err_accept", {63'd0, err_o}, {63'd0, (incl && (p == 0 || p > 164))});
    @(posedge clk); #1;
    cb_valid_i = 1'b0;
    check("err_pulse_end", {63'd0, err_o}, 64'd0);
    check("ready_low", {63'd0, cb_ready_o}, 64'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cb_ready_o) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("hdr_done", 64'(exp_q.size()) + {63'd0, !cb_ready_o}, 64'd0);
`ifdef PKT_HDR_STATS_EN
    check("bits_total", {32'd0, hdr_bits_total_o}, {32'd0, exp_total});
`endif
  endtask

  initial begin
    int stalls, n;
    logic [40:0] snap;
    logic saw_ones;

    #1;
    check("rst_outputs", {23'd0, cw_valid_o, obs_cw(), err_o}, 64'd0);
    check("rst_ready", {63'd0, cb_ready_o}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(1'b0, 0, 4, 9);
    @(posedge clk); #1;
    check("ready_back", {62'd0, cb_ready_o, cw_valid_o}, 64'd2);
    wait_done();

    send(1'b1, 0, 1, 5);   wait_done();
    send(1'b1, 3, 7, 300); wait_done();

    cw_ready_i = 1'b0;
    send(1'b1, 3, 7, 300);
    stalls = 0;
    snap   = '0;
    n      = 0;
    while ((exp_q.size() != 0 || !cb_ready_o) && n < 100) begin
      if (cw_valid_o && cw_data_o == 32'h1E1 && cw_bit_cnt_o == 6'd9 && stalls < 5) begin
        if (stalls == 0) snap = obs_cw();
        else check("stall_stable", {23'd0, obs_cw()}, {23'd0, snap});
        check("stall_ready", {63'd0, cb_ready_o}, 64'd0);
        cw_ready_i = 1'b0;
        stalls++;
      end else begin
        cw_ready_i = 1'b1;
      end
      @(posedge clk); #1; n++;
    end
    check("stall_count", 64'(stalls), 64'd5);
    cw_ready_i = 1'b1;
    wait_done();

    send(1'b1, 2, 200, 40); wait_done();
    send(1'b1, 0, 0, 40);   wait_done();

    send(1'b1, 1, 2, 0);       wait_done();
    send(1'b1, 0, 5, 1023);    wait_done();
    send(1'b1, 31, 36, 65535); wait_done();
    send(1'b1, 4, 37, 127);    wait_done();
    send(1'b1, 7, 164, 4096);  wait_done();

    send(1'b1, 3, 7, 300);
    saw_ones = 1'b0;
    n = 0;
    while (n < 50) begin
      if (cw_insert_ones_o) begin
        rst_n = 1'b0;
        saw_ones = 1'b1;
        break;
      end
      @(posedge clk); #1; n++;
    end
    check("reached_lblk_ones", {63'd0, saw_ones}, 64'd1);
    #1;
    exp_q.delete();
`ifdef PKT_HDR_STATS_EN
    exp_total = '0;
    check("rst_bits_total", {32'd0, hdr_bits_total_o}, 64'd0);
`endif
    check("midrst_outputs", {23'd0, cw_valid_o, obs_cw(), err_o}, 64'd0);
    check("midrst_ready", {63'd0, cb_ready_o}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {62'd0, cw_valid_o, cb_ready_o}, 64'd1);
    send(1'b1, 3, 7, 300); wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_hdr_cw_gen.md
Name: pkt_hdr_cw_gen

Overview:
JPEG2000 packet-header codeword generator, single quality layer, one code-block per precinct, so the tag trees degenerate to a single leaf.
Accepts one code-block descriptor per packet. Emits the packet header as a sequence of variable-length codewords: empty/non-empty bit, inclusion, zero-bitplanes, number of passes, Lblock signalling, length field.
Feeds the header bit assembler directly over the cw_* handshake; the assembler does byte packing and 0xFF bit-stuffing.

Parameters:
HDR_DATA_W, 32, codeword data width
BIT_CNT_W, 6, codeword bit-count width
ZBP_W, 5, zero-bitplane count width
PASS_W, 8, coding-pass count width
LEN_W, 16, code-block byte-length width
LBLOCK_INIT, 3, initial Lblock value

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cb_valid_i  in  1  descriptor valid
cb_ready_o  out  1  descriptor accepted when valid&ready
cb_incl_i  in  1  code-block included in this packet
cb_zbp_i  in  ZBP_W  missing MSB bitplanes
cb_passes_i  in  PASS_W  coding passes, legal 1..164
cb_len_i  in  LEN_W  code-block contribution in bytes
cw_valid_o  out  1  codeword valid
cw_last_o  out  1  final codeword of packet header
cw_insert_zero_o  out  1  emit cw_bit_cnt_o zero bits, data ignored
cw_insert_ones_o  out  1  emit cw_bit_cnt_o one bits, data ignored
cw_bit_cnt_o  out  BIT_CNT_W  codeword length, 1..32
cw_data_o  out  HDR_DATA_W  codeword right-justified; bit [cnt-1] sent first
cw_ready_i  in  1  downstream accepts codeword
err_o  out  1  one-cycle pulse: illegal pass count

Behaviour:
- Reset: all outputs 0 except cb_ready_o=1; state IDLE. Reset mid-header aborts it and emits no further codewords.
- IDLE: cb_ready_o=1. On accept, register the descriptor, compute k, drop cb_ready_o, go to HEAD.
- Latency: first cw_valid_o one cycle after accept. Every codeword is a registered output held stable until cw_valid_o&cw_ready_i; then advance. cb_ready_o stays 0 until the last codeword handshakes.
- Illegal descriptor: incl=1 with passes=0 or passes>164. Pulse err_o on the accept cycle and treat as incl=0.
- HEAD, incl=0: data=0, cnt=1, last=1, then IDLE.
- HEAD, incl=1: data=2'b11 (non-empty, inclusion), cnt=2, then ZBP.
- ZBP: if zbp>0, insert_zero, cnt=zbp. Then ZBP_END: data=1, cnt=1.
- PASSES codeword:
  - p=1: '0', 1 bit.
  - p=2: '10', 2 bits.
  - 3..5: '11' followed by (p-3) in 2 bits; 4 bits total.
  - 6..36: '1111' followed by (p-6) in 5 bits; 9 bits total.
  - 37..164: nine 1s followed by (p-37) in 7 bits; 16 bits total.
- Lblock signalling:
  - need = bits to represent len (0 gives 0); fl = floor(log2(passes)).
  - k = max(0, need - LBLOCK_INIT - fl).
  - LBLK_ONES: insert_ones, cnt=k; state skipped when k=0.
  - LBLK_ZERO: data=0, cnt=1, always emitted.
- LENGTH: data=len, cnt=LBLOCK_INIT+k+fl, last=1, then IDLE. cnt≤32 is guaranteed by the widths.
- insert_zero/insert_ones are never both 1 and never asserted with cnt=0.

Optional Feature:
- Macro PKT_HDR_STATS_EN.
- When defined: adds output hdr_bits_total_o [31:0], the running sum of cw_bit_cnt_o over all cw handshakes. Cleared by reset, wraps modulo 2^32.
- When undefined: port and counter absent, no other change.

Decomposition:
- Package pkt_hdr_pkg holds:
  - state enum {IDLE, HEAD, ZBP, ZBP_END, PASSES, LBLK_ONES, LBLK_ZERO, LENGTH};
  - pass-range constants (1, 2, 5, 36, 164);
  - functions bits_needed() and floor_log2().
- One combinational sub-module, hdr_pass_cw_enc: passes in, {data, cnt} out.

Test Plan:
- incl=0, ready held 1 -> single codeword data=0 cnt=1 last=1; cb_ready_o back to 1 the next cycle.
- incl=1 zbp=0 passes=1 len=5 -> codewords, no insert_zero:
  - 11/2, 1/1, 0/1, 0/1;
  - 101/3 with last=1.
- incl=1 zbp=3 passes=7 len=300 -> codewords:
  - 11/2, insert_zero cnt3, 1/1;
  - 0x1E1/9, insert_ones cnt4, 0/1;
  - 0x12C/9 with last=1.
- Case 3 with cw_ready_i low 5 cycles during the 0x1E1 codeword -> outputs stable, cb_ready_o=0, no codeword lost or duplicated.
- passes=200 incl=1 -> err_o pulses 1 cycle; single 0/1 last codeword.
- Assert rst_n during LBLK_ONES -> all outputs 0 and cb_ready_o=1 after reset; next descriptor produces a correct full header.
